// File: rtl/micro_loader_pkg.sv
// Shared command codes, acknowledge constants and FSM state encoding for the
// micro core program loader.
package micro_loader_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
   localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
   localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
   localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
   localparam logic [7:0] CMD_RST  = 8'h5A;  // 'Z'
   localparam logic [7:0] ACK_ERR  = 8'h3F;  // '?'

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_HI,
      ST_LO,
      ST_ACK
   } state_t;

endpackage

// File: rtl/micro_loader_if.sv
// Byte stream, acknowledge handshake, instruction RAM write port and core
// controls between the loader (master) and its surroundings (slave).
interface micro_loader_if #(
   parameter int IRAM_ADDR_BITS = 8
);
   logic [7:0]                rx_data;
   logic                      rx_valid;
   logic [7:0]                tx_data;
   logic                      tx_valid;
   logic                      tx_ready;
   logic [IRAM_ADDR_BITS-1:0] iram_wa;
   logic                      iram_wen;
   logic [15:0]               iram_din;
   logic                      PCenable;
   logic                      cpu_reset;
   logic                      busy;
   logic                      err;

   modport master (
      input  rx_data, rx_valid, tx_ready,
      output tx_data, tx_valid, iram_wa, iram_wen, iram_din,
             PCenable, cpu_reset, busy, err
   );

   modport slave (
      output rx_data, rx_valid, tx_ready,
      input  tx_data, tx_valid, iram_wa, iram_wen, iram_din,
             PCenable, cpu_reset, busy, err
   );
endinterface

// File: rtl/micro_loader_rx_timeout.sv
// Inter-byte idle counter: counts enabled cycles without a byte and flags the
// TIMEOUT_CYCLES-th one.
module rx_timeout #(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)       cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= cnt + CW'(1);
   end

   // cnt holds the number of idle cycles already seen, so the current cycle is the last one at LIMIT
   assign expired = enable & ~clear & (cnt == LIMIT);

endmodule

// File: rtl/micro_loader.sv
// Host command decoder, instruction RAM loader and run controller for the
// micro core; one acknowledge byte is returned per command.
module micro_loader
   import micro_loader_pkg::*;
#(
   parameter int IRAM_ADDR_BITS = 8,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input logic            clk,
   input logic            reset,
   micro_loader_if.master bus
);
   state_t                    state;
   logic                      run_flag;
   logic [IRAM_ADDR_BITS-1:0] addr;
   logic [8:0]                remaining;
   logic [7:0]                hi_byte;
   logic [7:0]                checksum;
   logic                      in_load;
   logic                      tmo_expired;

   assign in_load = (state == ST_LEN) || (state == ST_HI) || (state == ST_LO);

   rx_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (bus.rx_valid),
      .enable (in_load),
      .expired(tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state         <= ST_IDLE;
         run_flag      <= 1'b0;
         addr          <= '0;
         remaining     <= '0;
         hi_byte       <= '0;
         checksum      <= '0;
         bus.tx_data   <= '0;
         bus.tx_valid  <= 1'b0;
         bus.iram_wa   <= '0;
         bus.iram_wen  <= 1'b0;
         bus.iram_din  <= '0;
         bus.PCenable  <= 1'b0;
         bus.cpu_reset <= 1'b0;
         bus.busy      <= 1'b0;
         bus.err       <= 1'b0;
      end else begin
         bus.iram_wen  <= 1'b0;
         bus.cpu_reset <= 1'b0;
         bus.err       <= 1'b0;
         bus.PCenable  <= run_flag & ~bus.busy;

         if (in_load && tmo_expired) begin
            // Abort: a pending high half is simply never written
            bus.err      <= 1'b1;
            bus.busy     <= 1'b0;
            bus.tx_data  <= ACK_ERR;
            bus.tx_valid <= 1'b1;
            state        <= ST_ACK;
         end else begin
            unique case (state)
               ST_IDLE: if (bus.rx_valid) begin
                  state        <= ST_ACK;
                  bus.tx_valid <= 1'b1;
                  bus.tx_data  <= bus.rx_data;
                  case (bus.rx_data)
                     CMD_LOAD: begin
                        run_flag     <= 1'b0;
                        bus.busy     <= 1'b1;
                        bus.PCenable <= 1'b0;
                        bus.tx_valid <= 1'b0;
                        addr         <= '0;
                        checksum     <= '0;
                        state        <= ST_LEN;
                     end
                     CMD_RUN: begin
                        run_flag     <= 1'b1;
                        bus.PCenable <= 1'b1;
                     end
                     CMD_HALT: begin
                        run_flag     <= 1'b0;
                        bus.PCenable <= 1'b0;
                     end
                     CMD_STEP: bus.PCenable  <= 1'b1;
                     CMD_RST:  bus.cpu_reset <= 1'b1;
                     default: begin
                        bus.err     <= 1'b1;
                        bus.tx_data <= ACK_ERR;
                     end
                  endcase
               end
               ST_LEN: if (bus.rx_valid) begin
                  // A length byte of zero encodes 256 words
                  remaining <= {(bus.rx_data == 8'd0), bus.rx_data};
                  state     <= ST_HI;
               end
               ST_HI: if (bus.rx_valid) begin
                  hi_byte  <= bus.rx_data;
                  checksum <= checksum + bus.rx_data;
                  state    <= ST_LO;
               end
               ST_LO: if (bus.rx_valid) begin
                  bus.iram_wen <= 1'b1;
                  bus.iram_wa  <= addr;
                  bus.iram_din <= {hi_byte, bus.rx_data};
                  addr         <= addr + 1'b1;
                  remaining    <= remaining - 9'd1;
                  checksum     <= checksum + bus.rx_data;
                  if (remaining == 9'd1) begin
                     bus.cpu_reset <= 1'b1;
                     bus.busy      <= 1'b0;
                     bus.tx_data   <= checksum + bus.rx_data;
                     bus.tx_valid  <= 1'b1;
                     state         <= ST_ACK;
                  end else begin
                     state <= ST_HI;
                  end
               end
               ST_ACK: begin
                  if (bus.rx_valid) bus.err <= 1'b1;
                  if (bus.tx_ready) begin
                     bus.tx_valid <= 1'b0;
                     state        <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
